// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO pointer/flag controller.
package fifo_pkg;

    localparam int ADDR_W_DEFAULT = 3;
    localparam int DATA_W         = 15;

    // Pointer with wrap bit in the MSB and memory address in the low bits.
    typedef logic [ADDR_W_DEFAULT:0] ptr_t;

    // Error-state machine: ERROR while any sticky error flag is held.
    typedef enum logic {
        NORMAL = 1'b0,
        ERROR  = 1'b1
    } err_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments modulo 2*DEPTH, synchronous clear.
module fifo_ptr #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W:0]   ptr
);

    logic [ADDR_W:0] ptr_reg;
    logic [ADDR_W:0] ptr_next;

    // Clear dominates; otherwise advance by one on an accepted access.
    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = ptr_reg + 1'b1;
        end
    end

    // Pointer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a dual-address memory into a synchronous FIFO.
// Data never passes through here; only addresses, enables and status.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clrErr,
    output logic              memWen,
    output logic              memRen,
    output logic [ADDR_W-1:0] memWrAddr,
    output logic [ADDR_W-1:0] memRdAddr,
    output logic              rdValid,
    output logic              full,
    output logic              empty,
    output logic              almostFull,
    output logic              almostEmpty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push_ok;
    logic            pop_ok;
    logic            wr_inc;
    logic            rd_inc;
    logic            ovf_set;
    logic            udf_set;
    logic            ovf_reg;
    logic            udf_reg;
    logic            rd_valid_reg;
    err_state_t      state_reg;
    err_state_t      state_next;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_inc),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_inc),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    // Status derived purely from registered pointers.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                         (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count       = wr_ptr - rd_ptr;
    assign almostFull  = (count >= AF_CNT);
    assign almostEmpty = (count <= AE_CNT);

    // Acceptance uses registered flags only: no fall-through, no pop-makes-room.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign wr_inc  = push_ok & ~flush;
    assign rd_inc  = pop_ok & ~flush;

    assign memWen    = wr_inc;
    assign memRen    = rd_inc;
    assign memWrAddr = wr_ptr[ADDR_W-1:0];
    assign memRdAddr = rd_ptr[ADDR_W-1:0];

    // Rejected requests raise errors; flush overrides everything.
    assign ovf_set = push & full & ~flush;
    assign udf_set = pop & empty & ~flush;

    // Memory output is valid one cycle after an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_inc;
        end
    end

    assign rdValid = rd_valid_reg;

    // Per-flag sticky bits; a set in the same cycle beats clrErr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (flush) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_set | (ovf_reg & ~clrErr);
            udf_reg <= udf_set | (udf_reg & ~clrErr);
        end
    end

    // Error FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Error FSM next-state: enter on any set, leave on a clean clear.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL: if (ovf_set | udf_set) state_next = ERROR;
            ERROR:  if ((clrErr | flush) & ~(ovf_set | udf_set)) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // Error FSM outputs: flags visible only while in ERROR.
    always_comb begin
        overflow  = (state_reg == ERROR) & ovf_reg;
        underflow = (state_reg == ERROR) & udf_reg;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl with a behavioural 8x15 memory.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              flush = 1'b0;
    logic              clrErr = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              memWen, memRen, rdValid, full, empty;
    logic              almostFull, almostEmpty, overflow, underflow;
    logic [2:0]        memWrAddr, memRdAddr;
    logic [3:0]        count;

    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .clrErr      (clrErr),
        .memWen      (memWen),
        .memRen      (memRen),
        .memWrAddr   (memWrAddr),
        .memRdAddr   (memRdAddr),
        .rdValid     (rdValid),
        .full        (full),
        .empty       (empty),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Memory model: synchronous write, registered read.
    always @(posedge clk) begin
        if (memWen) mem[memWrAddr] <= din;
        if (memRen) dout <= mem[memRdAddr];
    end

    typedef struct {
        bit push, pop, flush, clr;
        int din;
        bit wen, ren;
        int wa, ra, cnt;
        bit full, empty, af, ae, ovf, udf, rv;
        int dq;
    } vec_t;

    vec_t vecs[$];

    // Flags follow from the expected count: full=8, empty=0, af>=6, ae<=2.
    task automatic add(input bit pu, po, fl, ce, input int d,
                       input bit wen, ren, input int wa, ra, cnt,
                       input bit ov, ud, rv, input int dq);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.clr = ce; v.din = d;
        v.wen = wen; v.ren = ren; v.wa = wa; v.ra = ra; v.cnt = cnt;
        v.full = (cnt == 8); v.empty = (cnt == 0);
        v.af = (cnt >= 6); v.ae = (cnt <= 2);
        v.ovf = ov; v.udf = ud; v.rv = rv; v.dq = dq;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit pu, po, fl, ce, input int d);
        @(negedge clk);
        push = pu; pop = po; flush = fl; clrErr = ce; din = d[DATA_W-1:0];
        #1;
    endtask

    initial begin
        // ---- Build the vector table ----
        //   pu po fl ce din      wen ren wa ra cnt ov ud rv dq
        add(0, 0, 0, 0, 0,        0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 'h1100,   1, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 'h7531,   1, 0, 1, 0, 1,  0, 0, 0, 0);
        add(1, 0, 0, 0, 'h7D01,   1, 0, 2, 0, 2,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,        0, 0, 3, 0, 3,  0, 0, 0, 0);
        add(0, 1, 0, 0, 0,        0, 1, 3, 0, 3,  0, 0, 0, 0);
        add(0, 1, 0, 0, 0,        0, 1, 3, 1, 2,  0, 0, 1, 'h1100);
        add(0, 1, 0, 0, 0,        0, 1, 3, 2, 1,  0, 0, 1, 'h7531);
        add(0, 0, 0, 0, 0,        0, 0, 3, 3, 0,  0, 0, 1, 'h7D01);
        // Fill to full starting at address 3.
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 0, i + 1, 1, 0, (3 + i) % 8, 3, i, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,        0, 0, 3, 3, 8,  0, 0, 0, 0);
        add(1, 0, 0, 0, 'h7FFF,   0, 0, 3, 3, 8,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,        0, 0, 3, 3, 8,  1, 0, 0, 0);
        // Push+pop while full: only the pop is taken.
        add(1, 1, 0, 0, 'h7FFF,   0, 1, 3, 3, 8,  1, 0, 0, 0);
        add(0, 0, 0, 1, 0,        0, 0, 3, 4, 7,  1, 0, 1, 1);
        add(0, 0, 0, 0, 0,        0, 0, 3, 4, 7,  0, 0, 0, 0);
        // Drain remaining 7 entries (data 2..8 at addresses 4..2).
        for (int j = 0; j < 7; j++)
            add(0, 1, 0, 0, 0, 0, 1, 3, (4 + j) % 8, 7 - j, 0, 0, j > 0, j + 1);
        add(0, 0, 0, 0, 0,        0, 0, 3, 3, 0,  0, 0, 1, 8);
        // Underflow when empty.
        add(0, 1, 0, 0, 0,        0, 0, 3, 3, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,        0, 0, 3, 3, 0,  0, 1, 0, 0);
        add(1, 1, 0, 0, 'h0055,   1, 0, 3, 3, 0,  0, 1, 0, 0);
        add(0, 0, 0, 0, 0,        0, 0, 4, 3, 1,  0, 1, 0, 0);
        add(0, 1, 0, 0, 0,        0, 1, 4, 3, 1,  0, 1, 0, 0);
        add(0, 0, 0, 1, 0,        0, 0, 4, 4, 0,  0, 1, 1, 'h0055);
        add(0, 0, 0, 0, 0,        0, 0, 4, 4, 0,  0, 0, 0, 0);
        // Interleaved wrap: addresses 4..7,0..3, steady count 1.
        add(1, 0, 0, 0, 'h100,    1, 0, 4, 4, 0,  0, 0, 0, 0);
        for (int k = 1; k < 8; k++)
            add(1, 1, 0, 0, 'h100 + k, 1, 1, (4 + k) % 8, (3 + k) % 8, 1,
                0, 0, k >= 2, 'h100 + k - 2);
        add(0, 1, 0, 0, 0,        0, 1, 4, 3, 1,  0, 0, 1, 'h106);
        add(0, 0, 0, 0, 0,        0, 0, 4, 4, 0,  0, 0, 1, 'h107);

        // ---- Reset ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            push = vecs[i].push; pop = vecs[i].pop;
            flush = vecs[i].flush; clrErr = vecs[i].clr;
            din = vecs[i].din[DATA_W-1:0];
            #1;
            $display("vec %0d: push=%0b pop=%0b cnt=%0d wa=%0d ra=%0d wen=%0b ren=%0b rv=%0b dout=%h ovf=%0b udf=%0b",
                     i, push, pop, count, memWrAddr, memRdAddr, memWen, memRen,
                     rdValid, dout, overflow, underflow);
            check($sformatf("v%0d memWen", i), memWen, vecs[i].wen);
            check($sformatf("v%0d memRen", i), memRen, vecs[i].ren);
            check($sformatf("v%0d memWrAddr", i), memWrAddr, vecs[i].wa);
            check($sformatf("v%0d memRdAddr", i), memRdAddr, vecs[i].ra);
            check($sformatf("v%0d count", i), count, vecs[i].cnt);
            check($sformatf("v%0d full", i), full, vecs[i].full);
            check($sformatf("v%0d empty", i), empty, vecs[i].empty);
            check($sformatf("v%0d almostFull", i), almostFull, vecs[i].af);
            check($sformatf("v%0d almostEmpty", i), almostEmpty, vecs[i].ae);
            check($sformatf("v%0d overflow", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d underflow", i), underflow, vecs[i].udf);
            check($sformatf("v%0d rdValid", i), rdValid, vecs[i].rv);
            if (vecs[i].rv)
                check($sformatf("v%0d dout", i), dout, vecs[i].dq);
        end

        // ---- Async reset mid-pop with count 5 ----
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 'h200 + i);
        drive(0, 1, 0, 0, 0);
        $display("rst seq: cnt=%0d ren=%0b", count, memRen);
        check("rst pre count", count, 5);
        drive(0, 1, 0, 0, 0);
        check("rst pre rdValid", rdValid, 1);
        check("rst pre dout", dout, 'h200);
        #2 rst_n = 1'b0;
        #1;
        $display("rst asserted: cnt=%0d empty=%0b rv=%0b ren=%0b", count, empty, rdValid, memRen);
        check("rst count", count, 0);
        check("rst empty", empty, 1);
        check("rst almostEmpty", almostEmpty, 1);
        check("rst rdValid", rdValid, 0);
        check("rst memRen", memRen, 0);
        check("rst memRdAddr", memRdAddr, 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ---- Flush with count 4 ----
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 'h300 + i);
        drive(1, 1, 1, 0, 'h3FF);
        $display("flush cycle: cnt=%0d wen=%0b ren=%0b", count, memWen, memRen);
        check("flush count before", count, 4);
        check("flush memWen", memWen, 0);
        check("flush memRen", memRen, 0);
        drive(0, 0, 0, 0, 0);
        $display("after flush: cnt=%0d empty=%0b rv=%0b", count, empty, rdValid);
        check("flush count after", count, 0);
        check("flush empty", empty, 1);
        check("flush rdValid", rdValid, 0);
        check("flush memWrAddr", memWrAddr, 0);

        // ---- Set beats clrErr; flush clears errors ----
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        $display("pop+clrErr on empty: udf=%0b", underflow);
        check("set beats clr underflow", underflow, 1);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        $display("after flush: udf=%0b", underflow);
        check("flush clears underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that turns an 8-entry x 15-bit dual-address memModule into a synchronous FIFO.
- Accepts push/pop requests and drives the memModule Wen, Ren, wrAddr and rdAddr ports.
- Produces full/empty/level status, almost-full/almost-empty thresholds, sticky overflow/underflow errors and a read-data-valid strobe.
- Write data travels from the producer straight to memModule datain; no data passes through this block.

Parameters:
- ADDR_W, 3, memory address width.
- DEPTH, 2**ADDR_W (8), number of entries; always a power of two.
- AF_LEVEL, 6, almostFull asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almostEmpty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request; producer holds memModule datain valid in the same cycle.
- pop  in  1  read request.
- flush  in  1  synchronous clear of FIFO contents and error flags.
- clrErr  in  1  synchronous clear of the sticky error flags.
- memWen  out  1  to memModule Wen.
- memRen  out  1  to memModule Ren.
- memWrAddr  out  ADDR_W  to memModule wrAddr.
- memRdAddr  out  ADDR_W  to memModule rdAddr.
- rdValid  out  1  memModule dataOut holds the popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count >= AF_LEVEL.
- almostEmpty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a rejected push.
- underflow  out  1  sticky; set by a rejected pop.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wrPtr = rdPtr = 0, count = 0.
  - empty = 1, almostEmpty = 1, full = 0, almostFull = 0.
  - overflow = underflow = 0, rdValid = 0.
  - memWen = memRen = 0, memWrAddr = memRdAddr = 0.
  - Reset asserted mid-transfer discards all contents with no partial update.
- Pointers:
  - wrPtr and rdPtr are ADDR_W+1 bits; the MSB is the wrap bit and the low ADDR_W bits form the address.
  - Each pointer increments modulo 2*DEPTH, so address 7 wraps to 0 with the wrap bit toggled.
  - empty = (wrPtr == rdPtr).
  - full = (addresses equal and wrap bits differ).
  - count = wrPtr - rdPtr, modulo 2**(ADDR_W+1).
- Acceptance is combinational from registered state:
  - pushOk = push & ~full.
  - popOk = pop & ~empty.
  - full rejects a push even when a pop is accepted in the same cycle.
  - empty rejects a pop even when a push is accepted in the same cycle; there is no fall-through.
- Memory drive, all combinational:
  - memWen = pushOk.
  - memRen = popOk.
  - memWrAddr = wrPtr[ADDR_W-1:0].
  - memRdAddr = rdPtr[ADDR_W-1:0].
- Pointer update on the clock edge: wrPtr += pushOk; rdPtr += popOk.
- Simultaneous pushOk and popOk: count is unchanged and both pointers advance. The addresses differ, because count is neither 0 nor DEPTH.
- Read latency:
  - memModule registers dataOut one cycle after the edge that samples Ren/rdAddr.
  - rdValid is popOk delayed one cycle; rdValid is never asserted except on such a cycle.
- Errors:
  - overflow sets on push & full; underflow sets on pop & empty.
  - Both hold until clrErr, flush or reset.
  - Set wins over clrErr in the same cycle.
- flush:
  - Pointers go to 0 on the next edge and error flags clear.
  - rdValid is forced to 0 on the following cycle.
  - memWen and memRen are forced to 0 during the flush cycle.
  - flush has priority over push and pop.
- Error-state FSM, states NORMAL and ERROR:
  - NORMAL -> ERROR on any overflow/underflow set.
  - ERROR -> NORMAL on clrErr or flush when no error is set in that cycle.
  - overflow and underflow are decoded from this state plus the per-flag sticky bits.

Decomposition:
- Package fifo_pkg holds:
  - ADDR_W_DEFAULT = 3, DATA_W = 15.
  - typedef ptr_t = logic [ADDR_W:0].
  - enum err_state_t {NORMAL, ERROR}.
- One sub-module, fifo_ptr: a wrap-bit pointer register with inc and clr inputs, instantiated twice (write and read).
- Flag, count and error logic stay in fifo_ctrl.
- Bench instantiates fifo_ctrl with memModule.

Test Plan:
- Reset, then push 0x1100, 0x7531 (30001), 0x7D01 (32001) at addresses 0, 1, 2 -> count = 3, almostEmpty = 0; three pops return the same values with rdValid one cycle after each pop, then empty = 1.
- Push 8 words 0x0001..0x0008 -> full = 1 after the 8th and almostFull from the 6th; a 9th push -> memWen = 0, overflow = 1, count stays 8.
- While full, assert push and pop together -> pop accepted, push rejected, count = 7, overflow set; clrErr -> overflow = 0 and FSM returns to NORMAL.
- While empty, assert pop -> memRen = 0, underflow = 1, rdValid stays 0; push and pop together when empty -> count = 1 and underflow set.
- Wrap check: fill/drain 3 entries, then push 8 and pop 8 interleaved, one of each per cycle after the first push -> memWrAddr sequence crosses 7 -> 0, data order preserved, count stays constant at 1 during steady state.
- Drop rst_n asynchronously with count = 5, mid-pop -> all outputs go to reset values immediately (empty = 1, rdValid = 0); separately, flush with count = 4 -> count = 0 next cycle and no rdValid.
